// File: rtl/simple_cpu_pkg.sv
// rtl/simple_cpu_pkg.sv - shared types, field positions and reset values for simple_cpu
package simple_cpu_pkg;

    // Instruction type field encoding
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_t;

    // ALU funct bit encoding
    localparam logic FUNCT_ADD = 1'b0;
    localparam logic FUNCT_SUB = 1'b1;

    // Instruction field bit positions (20-bit layout)
    localparam int TYPE_LSB  = 18;
    localparam int X1_LSB    = 16;
    localparam int X2_LSB    = 14;
    localparam int X3_LSB    = 12;
    localparam int OFF_LSB   = 4;
    localparam int OFF_W     = 8;
    localparam int FUNCT_BIT = 0;

    // Multicycle sequencer states
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        WB    = 2'b10
    } state_t;

    // Register file reset contents: regs[i] = i
    localparam logic [3:0][7:0] REG_RESET = {8'd3, 8'd2, 8'd1, 8'd0};

endpackage

// File: rtl/simple_cpu_alu.sv
// rtl/simple_cpu_alu.sv - combinational ADD/SUB unit for simple_cpu
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             funct,
    output logic [WIDTH-1:0] y
);

    // Wrapping add or subtract selected by funct; no flags are produced
    always_comb begin
        y = a + b;
        if (funct == FUNCT_SUB) begin
            y = a - b;
        end
    end

endmodule

// File: rtl/simple_cpu.sv
// rtl/simple_cpu.sv - multicycle 8-bit teaching CPU top (optional trace: SIMPLE_CPU_TRACE_EN)
module simple_cpu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 8,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    state_t                  state_q;
    state_t                  state_d;
    logic [INSTR_WIDTH-1:0]  ir;
    logic [DATA_WIDTH-1:0]   regs [4];
    logic [DATA_WIDTH-1:0]   dmem [DEPTH];

    // Decoded fields of the held instruction
    op_t                     op;
    logic [1:0]              x1;
    logic [1:0]              x2;
    logic [1:0]              x3;
    logic [OFF_W-1:0]        offset;
    logic                    funct;

    // Read ports, ALU and result registers
    logic [1:0]              rd_b_sel;
    logic [DATA_WIDTH-1:0]   rd_a;
    logic [DATA_WIDTH-1:0]   rd_b;
    logic [DATA_WIDTH-1:0]   alu_y;
    logic [ADDR_BITS-1:0]    ea;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]   data_q;

    // Write-back controls
    logic                    reg_we;
    logic [DATA_WIDTH-1:0]   reg_wdata;
    logic                    mem_we;

    logic                    unused_ir_bits;

    assign op       = op_t'(ir[TYPE_LSB +: 2]);
    assign x1       = ir[X1_LSB +: 2];
    assign x2       = ir[X2_LSB +: 2];
    assign x3       = ir[X3_LSB +: 2];
    assign offset   = ir[OFF_LSB +: OFF_W];
    assign funct    = ir[FUNCT_BIT];
    assign unused_ir_bits = &{1'b0, ir[3:1]};

    // A STORE needs X2 (base) and X1 (data); everything else reads X2 and X3,
    // so the second read port is steered rather than adding a third port.
    assign rd_b_sel = (op == OP_STORE) ? x1 : x3;
    assign rd_a     = regs[x2];
    assign rd_b     = regs[rd_b_sel];
    assign ea       = ADDR_BITS'(rd_a) + ADDR_BITS'(offset);

    simple_cpu_alu #(
        .WIDTH (DATA_WIDTH)
    ) u_alu (
        .a     (rd_a),
        .b     (rd_b),
        .funct (funct),
        .y     (alu_y)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write-back enables
    always_comb begin
        state_d   = FETCH;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        reg_wdata = data_q;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC:  state_d = WB;
            WB: begin
                state_d = FETCH;
                reg_we  = (op == OP_ALU) || (op == OP_LOAD);
                mem_we  = (op == OP_STORE);
                if (op == OP_LOAD) begin
                    reg_wdata = dmem[addr_q];
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Instruction capture in FETCH; operand results latched in EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir     <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (state_q == FETCH) begin
                ir <= instruction;
            end
            if (state_q == EXEC) begin
                addr_q <= ea;
                data_q <= (op == OP_ALU) ? alu_y : rd_b;
            end
        end
    end

    // Register file write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= DATA_WIDTH'(REG_RESET[i]);
            end
        end else if (reg_we) begin
            regs[x1] <= reg_wdata;
        end
    end

    // Data memory write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (mem_we) begin
            dmem[addr_q] <= data_q;
        end
    end

`ifdef SIMPLE_CPU_TRACE_EN
    // Retirement trace printed at every WB edge
    always @(posedge clk) begin
        if (rst && state_q == WB) begin
            case (op)
                OP_ALU:   $display("%0t %s %s x1=%0d x2=%0d x3=%0d -> regs[%0d]=%0h", $time, op.name(),
                                   funct ? "SUB" : "ADD", x1, x2, x3, x1, reg_wdata);
                OP_LOAD:  $display("%0t %s x1=%0d x2=%0d off=%0h -> regs[%0d]=dmem[%0h]=%0h", $time, op.name(),
                                   x1, x2, offset, x1, addr_q, reg_wdata);
                OP_STORE: $display("%0t %s x1=%0d x2=%0d off=%0h -> dmem[%0h]=%0h", $time, op.name(),
                                   x1, x2, offset, addr_q, data_q);
                default:  $display("%0t %s", $time, op.name());
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_simple_cpu.sv
// tb/tb_simple_cpu.sv - directed self-checking bench for simple_cpu
module tb_simple_cpu;
    import simple_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [19:0] instruction;

    int checks;
    int failures;

    simple_cpu #(
        .DATA_WIDTH  (8),
        .ADDR_BITS   (8),
        .INSTR_WIDTH (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction starting at a negedge in FETCH; returns at the negedge after WB.
    // The instruction bus is scrambled after FETCH to show only the FETCH sample matters.
    task automatic run_instr(input logic [19:0] instr);
        instruction = instr;
        @(posedge clk);
        @(negedge clk);
        instruction = 20'hFFFFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        instruction = 20'h00000;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
        check({tag, "_r0"}, 32'(dut.regs[0]), 32'(r0));
        check({tag, "_r1"}, 32'(dut.regs[1]), 32'(r1));
        check({tag, "_r2"}, 32'(dut.regs[2]), 32'(r2));
        check({tag, "_r3"}, 32'(dut.regs[3]), 32'(r3));
    endtask

    task automatic check_dmem_zero(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.dmem[i] !== 8'h00) nz++;
        end
        check(tag, 32'(nz), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        instruction = 20'h00000;

        // Reset held low
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dut.state_q), 32'(FETCH));
        check("rst_ir", 32'(dut.ir), 32'h0);
        check_regs("rst", 8'd0, 8'd1, 8'd2, 8'd3);

        // Release and run a NOP
        rst = 1'b1;
        run_instr(20'h00000);
        check_regs("nop", 8'd0, 8'd1, 8'd2, 8'd3);
        check_dmem_zero("nop_dmem_zero");
        check("nop_state", 32'(dut.state_q), 32'(FETCH));

        // ADD r0 = r1 + r3 = 4; ADD r1 = r0 + r3 = 7
        run_instr(20'h47000);
        check("add1_r0", 32'(dut.regs[0]), 32'd4);
        run_instr(20'h53000);
        check("add2_r1", 32'(dut.regs[1]), 32'd7);
        check("add2_r0_keep", 32'(dut.regs[0]), 32'd4);

        // SUB r3 = r0 - r2 = 2
        run_instr(20'h72001);
        check_regs("sub1", 8'd4, 8'd7, 8'd2, 8'd2);

        // STORE dmem[r2+15] = r1; STORE dmem[r3+22] = r0
        run_instr(20'hD80F0);
        check("st1_dmem17", 32'(dut.dmem[17]), 32'd7);
        run_instr(20'hCC160);
        check("st2_dmem24", 32'(dut.dmem[24]), 32'd4);
        check_regs("st_regs", 8'd4, 8'd7, 8'd2, 8'd2);

        // LOAD r3 = dmem[r2+15]; LOAD r1 = dmem[r0+20]
        run_instr(20'hB80F0);
        check("ld1_r3", 32'(dut.regs[3]), 32'd7);
        run_instr(20'h90140);
        check_regs("ld2", 8'd4, 8'd4, 8'd2, 8'd7);

        // ADD r2 = r2 + r2 with destination equal to both sources
        run_instr(20'h6A000);
        check("self_add_r2", 32'(dut.regs[2]), 32'd4);

        // Reset mid-program restores state
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_regs("rst2", 8'd0, 8'd1, 8'd2, 8'd3);
        check("rst2_dmem17", 32'(dut.dmem[17]), 32'd0);

        // SUB r0 = r0 - r1 wraps to 0xFF
        run_instr(20'h41001);
        check("sub_wrap_r0", 32'(dut.regs[0]), 32'hFF);

        // r0 -= r3 five times: 0xFF -> 0xF0
        for (int k = 0; k < 5; k++) run_instr(20'h43001);
        check("base_r0", 32'(dut.regs[0]), 32'hF0);

        // STORE dmem[(0xF0 + 0x20) mod 256] = r3
        run_instr(20'hF0200);
        check("st_wrap_dmem10", 32'(dut.dmem[8'h10]), 32'd3);
        check("st_wrap_dmemf0", 32'(dut.dmem[8'hF0]), 32'd0);

        // Reset asserted while an ADD is in EXEC
        instruction = 20'h47000;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_exec", 32'(dut.state_q), 32'(EXEC));
        rst = 1'b0;
        instruction = 20'h00000;
        repeat (3) @(negedge clk);
        check_regs("abort", 8'd0, 8'd1, 8'd2, 8'd3);
        check("abort_dmem10", 32'(dut.dmem[8'h10]), 32'd0);
        rst = 1'b1;
        run_instr(20'h00000);
        check_regs("abort_nop", 8'd0, 8'd1, 8'd2, 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
